// File: rtl/median_ctrl.sv
// Control sequencer for the 9-register median stage: gates pixel loads into the stage,
// then drives the compare/bypass schedule and flags when the stage output holds the median.
module median_ctrl #(
  parameter int unsigned NUM_REGISTERS = 9,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned PASS_W        = 3
) (
  input  logic CLK,
  input  logic nRST,
  input  logic DSI,
  output logic MED_DSI,
  output logic MED_BYP,
  output logic DSO,
  output logic BUSY
);

  localparam int unsigned LAST_PASS = (NUM_REGISTERS - 1) / 2;
  localparam int unsigned FINAL_LEN = (NUM_REGISTERS - 1) / 2;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_REGISTERS - 1);
  localparam logic [CNT_W-1:0]  CNT_FINAL  = CNT_W'(FINAL_LEN - 1);
  localparam logic [PASS_W-1:0] PASS_FINAL = PASS_W'(LAST_PASS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PASS_W-1:0]   pass;

  // Sequencer: state, cycle/pass counters and the registered DSO/BUSY flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      pass  <= '0;
      DSO   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DSO <= 1'b0;
          if (DSI) begin
            state <= LOAD;
            cnt   <= CNT_W'(1);
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          if (!DSI) begin
            // Short burst: drop the window; the next one fully reloads the stage.
            state <= IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= SORT;
            cnt   <= '0;
            pass  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SORT: begin
          if (pass == PASS_FINAL) begin
            if (cnt == CNT_FINAL) begin
              state <= DONE;
              cnt   <= '0;
              pass  <= '0;
              DSO   <= 1'b1;
              BUSY  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            pass <= pass + PASS_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          DSO <= 1'b0;
          if (DSI) begin
            state <= LOAD;
            cnt   <= CNT_W'(1);
            BUSY  <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pass  <= '0;
          DSO   <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Stage controls: loads blocked while sorting; pass p compares N-1-p cycles then bypasses.
  always_comb begin
    MED_DSI = DSI & (state != SORT);
    MED_BYP = 1'b1;
    if (state == SORT) begin
      if (pass == PASS_FINAL) begin
        MED_BYP = 1'b0;
      end else begin
        MED_BYP = (32'(cnt) + 32'(pass)) >= (NUM_REGISTERS - 1);
      end
    end
  end

endmodule

// File: tb/tb_median_ctrl.sv
// Directed bench for median_ctrl: load/sort sequencing, bypass schedule, DSO timing,
// short-burst abort, back-to-back windows and asynchronous reset mid-sort.
module tb_median_ctrl;

  localparam int unsigned N         = 9;
  localparam int unsigned SORT_CYC  = 40;

  logic CLK;
  logic nRST;
  logic DSI;
  logic MED_DSI;
  logic MED_BYP;
  logic DSO;
  logic BUSY;

  int checks;
  int errors;
  int cyc;
  int dso_cyc;
  int prev_dso_cyc;

  median_ctrl #(
    .NUM_REGISTERS(9),
    .CNT_W(4),
    .PASS_W(3)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .DSI(DSI),
    .MED_DSI(MED_DSI),
    .MED_BYP(MED_BYP),
    .DSO(DSO),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Drive n consecutive DSI-high cycles starting at the current negedge.
  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      DSI = 1'b1;
      #1 chk("load_med_dsi", 32'(MED_DSI), 32'd1);
      @(negedge CLK);
      chk("load_busy", 32'(BUSY), 32'd1);
      if (i < n - 1 || n < int'(N))
        chk("load_byp", 32'(MED_BYP), 32'd1);
    end
  endtask

  // Walk the 40 sort cycles against the hand schedule, then check the DONE cycle.
  task automatic sort_phase(input bit rand_dsi, input bit next_dsi);
    int p;
    int c;
    logic exp_byp;
    for (int k = 0; k < int'(SORT_CYC); k++) begin
      DSI = rand_dsi ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (k >= 36) begin
        exp_byp = 1'b0;
      end else begin
        p = k / 9;
        c = k % 9;
        exp_byp = (c >= 8 - p) ? 1'b1 : 1'b0;
      end
      chk("sort_byp", 32'(MED_BYP), 32'(exp_byp));
      chk("sort_med_dsi", 32'(MED_DSI), 32'd0);
      chk("sort_busy", 32'(BUSY), 32'd1);
      chk("sort_dso", 32'(DSO), 32'd0);
      @(negedge CLK);
    end
    DSI = next_dsi;
    #1;
    prev_dso_cyc = dso_cyc;
    dso_cyc = cyc;
    chk("done_dso", 32'(DSO), 32'd1);
    chk("done_busy", 32'(BUSY), 32'd0);
    chk("done_byp", 32'(MED_BYP), 32'd1);
    chk("done_med_dsi", 32'(MED_DSI), 32'(next_dsi));
  endtask

  task automatic idle_after_done();
    @(negedge CLK);
    chk("idle_dso", 32'(DSO), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);
    chk("idle_byp", 32'(MED_BYP), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    dso_cyc = 0;
    prev_dso_cyc = 0;
    DSI = 1'b0;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_dso", 32'(DSO), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_byp", 32'(MED_BYP), 32'd1);
    DSI = 1'b1;
    #1 chk("rst_med_dsi", 32'(MED_DSI), 32'd1);
    @(negedge CLK);
    chk("rst_hold_busy", 32'(BUSY), 32'd0);
    DSI = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);

    // Single window with the full bypass trace.
    load(N);
    sort_phase(1'b0, 1'b0);
    idle_after_done();

    // Back-to-back windows: DSI re-asserted in the DONE cycle.
    repeat (2) @(negedge CLK);
    load(N);
    sort_phase(1'b0, 1'b1);
    load(N);
    sort_phase(1'b0, 1'b0);
    chk("b2b_interval", 32'(dso_cyc - prev_dso_cyc), 32'(N + SORT_CYC));
    idle_after_done();

    // Short burst aborts without a result, then a full window still works.
    load(5);
    DSI = 1'b0;
    @(negedge CLK);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_byp", 32'(MED_BYP), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("abort_no_dso", 32'(DSO), 32'd0);
    end
    load(N);
    sort_phase(1'b0, 1'b0);
    idle_after_done();

    // Random DSI during sort must not disturb the schedule or DSO timing.
    load(N);
    sort_phase(1'b1, 1'b0);
    idle_after_done();

    // Asynchronous reset at sort cycle 17.
    load(N);
    DSI = 1'b0;
    repeat (17) @(negedge CLK);
    chk("pre_rst_busy", 32'(BUSY), 32'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_dso", 32'(DSO), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_byp", 32'(MED_BYP), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst_no_dso", 32'(DSO), 32'd0);
    end
    load(N);
    sort_phase(1'b0, 1'b0);
    idle_after_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
